// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the RV32M divide group.
//   Handles DIV, DIVU, REM and REMU. Not pipelined: one operation is in flight
//   at a time. done pulses for one cycle when a result is ready, and result
//   holds that value until the next accepted start.
//
// Ports
//   clock    : single clock; all state updates on posedge
//   reset    : synchronous, active-high
//   start    : request; accepted only in IDLE or DONE, ignored while busy
//   func     : 00=DIV 01=DIVU 10=REM 11=REMU; sampled with start
//   dividend : rs1 operand; sampled with start
//   divisor  : rs2 operand; sampled with start
//   result   : quotient (DIV/DIVU) or remainder (REM/REMU); valid when done=1
//   done     : single-cycle pulse; result is valid in this cycle
//   busy     : high in CALC and FINISH
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      func,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, dvsr;
  logic            q_neg, r_neg, sel_rem;

  // Operand decode for the start cycle.
  logic            is_signed, a_neg, b_neg, div_zero, ovf, fast, accept;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  // Iteration and final sign fix-up.
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] q_fin, r_fin;

  always_comb begin
    is_signed = ~func[0];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor  : divisor;
    div_zero  = (divisor == '0);
    ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    fast      = div_zero | ovf;
    accept    = start & ((state == IDLE) | (state == DONE));
    // Divide-by-zero wins over overflow; the two cannot coincide anyway.
    if (div_zero)
      fast_res = func[1] ? dividend : '1;
    else
      fast_res = func[1] ? '0 : dividend;
  end

  always_comb begin
    // {rem,quo} shifted left by one, minus divisor, in XLEN+1 bits; the top
    // bit is the borrow that decides restore vs. keep.
    trial = {rem, quo[XLEN-1]} - {1'b0, dvsr};
    q_fin = q_neg ? -quo : quo;
    r_fin = r_neg ? -rem : rem;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      DONE:    if (start) state_nxt = fast ? DONE : CALC;
               else       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC) | (state == FINISH);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      sel_rem <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      cnt     <= CW'(XLEN);
      rem     <= '0;
      quo     <= a_mag;
      dvsr    <= b_mag;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      sel_rem <= func[1];
      if (fast)
        result <= fast_res;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (!trial[XLEN]) begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end else if (state == FINISH) begin
      result <= sel_rem ? r_fin : q_fin;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (XLEN=32).
//   A table of {func, dividend, divisor, expected result, expected latency}
//   records is driven one by one; expected results go into a scoreboard queue
//   at issue and are popped and compared by a monitor whenever done is seen.
//   Hand-written sequences cover start-while-busy, reset mid-operation and
//   back-to-back issue in the done cycle.
module tb_div_iter;

  localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  func = '0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_iter #(.XLEN(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .func     (func),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
    if (f[0]) return f[1] ? (a % b) : (a / b);
    sa  = a;
    sbv = b;
    return f[1] ? 32'(sa % sbv) : 32'(sa / sbv);
  endfunction

  function automatic int model_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done result=%h", result);
      end else begin
        check("sb_result", result, sb.pop_front());
      end
    end
  end

  // Drive one request in the next cycle; returns #1 after the accept edge (cycle 1).
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(posedge clock); #1;
    start = 1'b1; func = f; dividend = a; divisor = b;
    sb.push_back(exp);
    @(posedge clock); #1;
    start = 1'b0; func = 2'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Wait for done starting from cycle n0 and check its cycle number and busy.
  task automatic wait_done(input int n0, input int lat, input string name);
    int n;
    bit busy_ok;
    n = n0;
    busy_ok = 1'b1;
    while (!done && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    check({name, "_done_cycle"}, 32'(n), 32'(lat));
    check({name, "_busy_while_calc"}, 32'(busy_ok), 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dcount;
    logic [1:0]  rf;
    logic [31:0] ra, rb;

    // Spec vectors with hand-derived expectations.
    vecs.push_back('{F_DIVU, 32'd100,         32'd7,          32'd14,         34});
    vecs.push_back('{F_REMU, 32'd100,         32'd7,          32'd2,          34});
    vecs.push_back('{F_DIV,  32'hFFFF_FFEC,   32'd3,          32'hFFFF_FFFA,  34});
    vecs.push_back('{F_REM,  32'hFFFF_FFEC,   32'd3,          32'hFFFF_FFFE,  34});
    vecs.push_back('{F_DIV,  32'd20,          32'hFFFF_FFFD,  32'hFFFF_FFFA,  34});
    vecs.push_back('{F_DIVU, 32'd5,           32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{F_REM,  32'hFFFF_FFFB,   32'd0,          32'hFFFF_FFFB,  1});
    vecs.push_back('{F_DIV,  32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{F_REM,  32'h8000_0000,   32'hFFFF_FFFF,  32'h0000_0000,  1});
    vecs.push_back('{F_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,  32'h0000_0000,  34});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,   32'd1,          32'hFFFF_FFFF,  34});
    vecs.push_back('{F_DIVU, 32'd7,           32'd100,        32'd0,          34});
    vecs.push_back('{F_REM,  32'd7,           32'hFFFF_FFFE,  32'd1,          34});
    vecs.push_back('{F_DIV,  32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD,  34});
    vecs.push_back('{F_REMU, 32'd0,           32'd0,          32'd0,          1});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,  32'd1,          34});
    // Random operands, expectations from the reference model.
    for (int i = 0; i < 12; i++) begin
      rf = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      vecs.push_back('{rf, ra, rb, model(rf, ra, rb), model_lat(rf, ra, rb)});
    end

    // Reset state.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Table-driven operations, each followed by a check that done is one
    // cycle wide and result is held in IDLE.
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done(1, vecs[i].lat, $sformatf("vec%0d", i));
      @(posedge clock); #1;
      check($sformatf("vec%0d_done_width", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_hold", i), result, vecs[i].exp);
    end

    // start during CALC is ignored.
    issue(F_DIVU, 32'd100, 32'd7, 32'd14);
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1; func = F_DIVU; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(6, 34, "ignored_start");

    // Reset in cycle 10 of an operation discards it.
    issue(F_DIVU, 32'd100, 32'd7, 32'd14);
    repeat (9) begin @(posedge clock); #1; end
    check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    sb.delete();
    reset = 1'b0;
    dcount = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    // Back-to-back: second start in the done cycle of the first.
    issue(F_DIVU, 32'd9, 32'd2, 32'd4);
    wait_done(1, 34, "b2b_first");
    start = 1'b1; func = F_DIVU; dividend = 32'd9; divisor = 32'd4;
    sb.push_back(32'd2);
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    wait_done(1, 34, "b2b_second");

    repeat (3) @(posedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
